membus_arb2: RTL and testbench
==============================

MEMBUS_ARB2 -- requirements
Module: membus_arb2

Interface
REQ-001 Parameter TIMEOUT, default 255: clk cycles allowed in ADDR without m_addr_ack before the cycle is aborted; legal range 1..255.
REQ-002 clk  input  1  system clock; all state changes on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 sN_rq_cyc, sN_rd_rq, sN_wr_rq, sN_fmc_select, sN_wr_rs  input  1 each  membus request/control from requester N (N = 0, 1).
REQ-005 sN_ma  input  15 [21:35]  word address from requester N.
REQ-006 sN_sel  input  4 [18:21]  module select from requester N.
REQ-007 sN_mb_write  input  36 [0:35]  write data from requester N.
REQ-008 sN_mb_read  output  36 [0:35]  read data to requester N.
REQ-009 sN_addr_ack, sN_rd_rs  output  1 each  acknowledges to requester N.
REQ-010 m_rq_cyc, m_rd_rq, m_wr_rq, m_fmc_select, m_wr_rs  output  1 each  control to shared memory bus.
REQ-011 m_ma  output  15 [21:35];  m_sel  output  4 [18:21];  m_mb_write  output  36 [0:35]  address, select and write data to the shared memory bus.
REQ-012 m_mb_read  input  36 [0:35];  m_addr_ack, m_rd_rs  input  1 each  responses from the shared memory bus.
REQ-013 timeout  output  1  one-cycle pulse on a TIMEOUT abort.
REQ-014 owner  output  1  index of the current or most recently granted requester.

Function
REQ-015 The state machine SHALL have exactly three states: IDLE, ADDR and DATA.
REQ-016 IDLE: all m_* outputs SHALL be 0 and all sN_* outputs SHALL be 0.
REQ-017 IDLE, exactly one sN_rq_cyc high: next state is ADDR with owner <= N.
REQ-018 IDLE, both requesters high: the requester not equal to owner SHALL win (round-robin).
REQ-019 Grant latency SHALL be 1 cycle: the request is sampled in IDLE and m_rq_cyc rises on the following cycle.
REQ-020 In ADDR and DATA, the m_* outputs SHALL combinationally follow the owner's sN_* inputs with no register stage.
REQ-021 In ADDR and DATA, owner's sN_mb_read, sN_addr_ack and sN_rd_rs SHALL combinationally follow m_mb_read, m_addr_ack and m_rd_rs.
REQ-022 The non-owner's response outputs SHALL be 0 at all times; its requests are held off and never dropped.
REQ-023 ADDR, m_addr_ack sampled high: latch wr_flag <= owner's sN_wr_rq and go to DATA.
REQ-024 ADDR, owner's sN_rq_cyc low before ack: abort to IDLE with no timeout pulse.
REQ-025 ADDR, counter reaches TIMEOUT with no ack: go to IDLE and pulse timeout for one cycle.
REQ-026 The ADDR counter SHALL be 8 bits, clear on entry to ADDR, increment each ADDR cycle and saturate at its maximum.
REQ-027 DATA, wr_flag = 0 (read): return to IDLE on the edge that samples m_rd_rs high.
REQ-028 DATA, wr_flag = 1 (write or read-modify-write): ignore m_rd_rs for release and return to IDLE on the edge that samples owner's sN_wr_rs high.
REQ-029 m_rd_rs SHALL still be forwarded during a read-modify-write.
REQ-030 A new request arriving during ADDR or DATA SHALL be sampled only after return to IDLE, with no back-to-back grant in the same cycle.
REQ-031 The non-owner SHALL therefore wait at least 1 IDLE cycle between cycles.
REQ-032 No timeout SHALL apply in DATA.

Reset
REQ-033 While reset is high, the block SHALL hold state IDLE, owner = 1 (so s0 wins the first tie), wr_flag = 0, counter = 0 and timeout = 0.
REQ-034 While reset is high, all outputs SHALL be 0, except owner which reads 1.
REQ-035 Reset asserted mid-cycle SHALL immediately drop all m_* outputs and sN_* outputs to 0.
REQ-036 On reset release, the block SHALL start in IDLE.

Verification
REQ-037 Read: core word 4 = 123; s0 reads ma = 4 -> m_rq_cyc rises 1 cycle after s0_rq_cyc; s0_mb_read = 123 while s0_rd_rs = 1; state = IDLE the next cycle; s1 outputs stay 0.
REQ-038 Tie: s0 and s1 request in the same cycle from reset -> s0 granted first (owner = 0); s1 granted after s0's rd_rs; then a new tie -> s0 wins again.
REQ-039 Write: s1 writes 36'o112233445566 to ma = 'o123 -> release only on s1_wr_rs, not on m_rd_rs; a subsequent s0 read of 'o123 returns 36'o112233445566.
REQ-040 Fast memory: s0 reads ma = 3 with fmc_select = 1, ff[3] = 36'o777777666666 -> s0_mb_read = 36'o777777666666.
REQ-041 Timeout: s0 requests sel = 4'b1111 with no memory responding, TIMEOUT = 8 -> exactly one timeout pulse 8 cycles after ADDR entry; a pending s1 request is granted afterwards.
REQ-042 Reset mid-DATA: reset pulsed while the owner waits on rd_rs -> all outputs 0 asynchronously; after release owner = 1 and the next request is granted normally.

Source files
------------

// File: rtl/membus_arb2_if.sv
// membus_arb2_if: one membus port, with requester controls/address/data and the memory's responses.
interface membus_arb2_if;
    logic         rq_cyc, rd_rq, wr_rq, fmc_select, wr_rs;
    logic [21:35] ma;
    logic [18:21] sel;
    logic [0:35]  mb_write, mb_read;
    logic         addr_ack, rd_rs;
    modport master (output rq_cyc, rd_rq, wr_rq, fmc_select, wr_rs, ma, sel, mb_write,
                    input  mb_read, addr_ack, rd_rs);
    modport slave  (input  rq_cyc, rd_rq, wr_rq, fmc_select, wr_rs, ma, sel, mb_write,
                    output mb_read, addr_ack, rd_rs);
endinterface

// File: rtl/membus_arb2.sv
// membus_arb2: two-requester round-robin arbiter onto one membus, with an address-phase timeout.
module membus_arb2 #(parameter int TIMEOUT = 255) (
    input  logic clk,
    input  logic reset,
    membus_arb2_if.slave  s0,
    membus_arb2_if.slave  s1,
    membus_arb2_if.master m,
    output logic timeout,
    output logic owner
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    state_t state, state_n;
    logic owner_n, wr_flag, wr_flag_n, timeout_n, busy;
    logic o_rq_cyc, o_wr_rq, o_wr_rs;
    logic [7:0] cnt, cnt_n;
    logic [59:0] r0, r1;
    assign r0 = {s0.rq_cyc, s0.rd_rq, s0.wr_rq, s0.fmc_select, s0.wr_rs, s0.ma, s0.sel, s0.mb_write};
    assign r1 = {s1.rq_cyc, s1.rd_rq, s1.wr_rq, s1.fmc_select, s1.wr_rs, s1.ma, s1.sel, s1.mb_write};
    assign busy = state != IDLE;
    assign o_rq_cyc = owner ? s1.rq_cyc : s0.rq_cyc;
    assign o_wr_rq = owner ? s1.wr_rq : s0.wr_rq;
    assign o_wr_rs = owner ? s1.wr_rs : s0.wr_rs;
    // Pure combinational forwarding; the async reset forces IDLE and so zeroes every path at once.
    assign {m.rq_cyc, m.rd_rq, m.wr_rq, m.fmc_select, m.wr_rs, m.ma, m.sel, m.mb_write} =
        busy ? (owner ? r1 : r0) : '0;
    assign {s0.mb_read, s0.addr_ack, s0.rd_rs} = (busy && !owner) ? {m.mb_read, m.addr_ack, m.rd_rs} : '0;
    assign {s1.mb_read, s1.addr_ack, s1.rd_rs} = (busy && owner) ? {m.mb_read, m.addr_ack, m.rd_rs} : '0;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            owner <= 1'b1;
            wr_flag <= 1'b0;
            cnt <= '0;
            timeout <= 1'b0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            wr_flag <= wr_flag_n;
            cnt <= cnt_n;
            timeout <= timeout_n;
        end
    always_comb begin
        state_n = state;
        owner_n = owner;
        wr_flag_n = wr_flag;
        timeout_n = 1'b0;
        cnt_n = (state != ADDR) ? '0 : (&cnt) ? cnt : cnt + 8'd1;
        case (state)
            IDLE:
                if (s0.rq_cyc || s1.rq_cyc) begin
                    state_n = ADDR;
                    owner_n = (s0.rq_cyc && s1.rq_cyc) ? ~owner : s1.rq_cyc;
                end
            ADDR:
                if (!o_rq_cyc) state_n = IDLE;
                else if (m.addr_ack) begin
                    state_n = DATA;
                    wr_flag_n = o_wr_rq;
                end else if (cnt == 8'(TIMEOUT - 1)) begin
                    state_n = IDLE;
                    timeout_n = 1'b1;
                end
            DATA: if (wr_flag ? o_wr_rs : m.rd_rs) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_membus_arb2.sv
// tb_membus_arb2: random and directed stimulus checked every cycle against a transaction-level arbiter model.
module tb_membus_arb2;
    localparam int TMO = 8;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tmo, owner;
    membus_arb2_if s0i();
    membus_arb2_if s1i();
    membus_arb2_if mi();
    membus_arb2 #(.TIMEOUT(TMO)) dut (.clk(clk), .reset(reset), .s0(s0i), .s1(s1i), .m(mi),
                                      .timeout(tmo), .owner(owner));
    always #5 clk = ~clk;
    int checks = 0, failures = 0;
    bit busy = 1'b0, own = 1'b1, acked = 1'b0, wflag = 1'b0, tp = 1'b0;
    int waited = 0;
    logic [59:0] mr;
    bit mem_on = 1'b0, mem_hold = 1'b0;
    int mph = 0;
    logic [0:35] core [0:32767];
    logic [0:35] ff [0:15];
    logic [0:35] d;
    int k;
    function automatic logic [59:0] reqv(bit n);
        return n ? {s1i.rq_cyc, s1i.rd_rq, s1i.wr_rq, s1i.fmc_select, s1i.wr_rs, s1i.ma, s1i.sel, s1i.mb_write}
                 : {s0i.rq_cyc, s0i.rd_rq, s0i.wr_rq, s0i.fmc_select, s0i.wr_rs, s0i.ma, s0i.sel, s0i.mb_write};
    endfunction
    function automatic logic [59:0] mout();
        return {mi.rq_cyc, mi.rd_rq, mi.wr_rq, mi.fmc_select, mi.wr_rs, mi.ma, mi.sel, mi.mb_write};
    endfunction
    function automatic bit rs(bit n);
        return n ? s1i.rd_rs : s0i.rd_rs;
    endfunction
    task automatic set_req(bit n, logic [59:0] v);
        if (n) {s1i.rq_cyc, s1i.rd_rq, s1i.wr_rq, s1i.fmc_select, s1i.wr_rs, s1i.ma, s1i.sel, s1i.mb_write} = v;
        else {s0i.rq_cyc, s0i.rd_rq, s0i.wr_rq, s0i.fmc_select, s0i.wr_rs, s0i.ma, s0i.sel, s0i.mb_write} = v;
    endtask
    // Bus tenure model: who holds the bus, whether the address was taken, and how long it has waited.
    always @(posedge clk or posedge reset)
        if (reset) begin
            busy = 1'b0;
            own = 1'b1;
            acked = 1'b0;
            wflag = 1'b0;
            waited = 0;
            tp = 1'b0;
        end else begin
            tp = 1'b0;
            if (!busy) begin
                if (s0i.rq_cyc || s1i.rq_cyc) begin
                    own = (s0i.rq_cyc && s1i.rq_cyc) ? !own : s1i.rq_cyc;
                    busy = 1'b1;
                    acked = 1'b0;
                    waited = 0;
                end
            end else begin
                mr = reqv(own);
                if (!acked) begin
                    waited++;
                    if (!mr[59]) busy = 1'b0;
                    else if (mi.addr_ack) begin
                        acked = 1'b1;
                        wflag = mr[57];
                    end else if (waited >= TMO) begin
                        busy = 1'b0;
                        tp = 1'b1;
                    end
                end else if (wflag ? mr[55] : mi.rd_rs) busy = 1'b0;
            end
        end
    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask
    task automatic compare();
        logic [37:0] resp;
        resp = {mi.mb_read, mi.addr_ack, mi.rd_rs};
        chk("m_bus", 64'(mout()), busy ? 64'(reqv(own)) : 64'd0);
        chk("s0_resp", 64'({s0i.mb_read, s0i.addr_ack, s0i.rd_rs}), (busy && !own) ? 64'(resp) : 64'd0);
        chk("s1_resp", 64'({s1i.mb_read, s1i.addr_ack, s1i.rd_rs}), (busy && own) ? 64'(resp) : 64'd0);
        chk("timeout", 64'(tmo), 64'(tp));
        chk("owner", 64'(owner), 64'(own));
    endtask
    // Simple memory: acks an address once, then returns old data with rd_rs and stores any write data.
    task automatic memory();
        mi.addr_ack = 1'b0;
        mi.rd_rs = 1'b0;
        if (!mi.rq_cyc || mi.sel == 4'hf) mph = 0;
        else if (mph == 0) begin
            mi.addr_ack = 1'b1;
            mph = 1;
        end else if (mph == 1 && !mem_hold) begin
            mi.mb_read = mi.fmc_select ? ff[mi.ma[32:35]] : core[mi.ma];
            mi.rd_rs = 1'b1;
            if (mi.wr_rq) begin
                if (mi.fmc_select) ff[mi.ma[32:35]] = mi.mb_write;
                else core[mi.ma] = mi.mb_write;
            end
            mph = 2;
        end
    endtask
    task automatic tick();
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
        if (mem_on) memory();
    endtask
    task automatic xfer(bit n, bit wr, bit fmc, logic [21:35] a, logic [0:35] wd, output logic [0:35] rd);
        int w = 0;
        set_req(n, {1'b1, 1'b1, wr, fmc, 1'b0, a, 4'h0, wd});
        while (!rs(n) && w < 30) begin
            tick();
            #1;
            w++;
        end
        chk("xfer_rd_rs", 64'(w < 30), 64'd1);
        rd = n ? s1i.mb_read : s0i.mb_read;
        if (wr) begin
            tick();
            #1;
            chk("rmw_hold", 64'(mi.rq_cyc), 64'd1);
            set_req(n, reqv(n) | (60'd1 << 55));
        end
        tick();
        #1;
        chk("release", 64'(mi.rq_cyc), 64'd0);
        set_req(n, '0);
    endtask
    initial begin
        logic [59:0] v;
        set_req(0, '0);
        set_req(1, '0);
        mi.addr_ack = 1'b0;
        mi.rd_rs = 1'b0;
        mi.mb_read = '0;
        tick();
        tick();
        #1;
        chk("rst_owner", 64'(owner), 64'd1);
        chk("rst_mbus", 64'(mout()), 64'd0);
        reset = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            for (int n = 0; n < 2; n++) begin
                v = reqv(n[0]);
                v[59] = v[59] ^ ($urandom_range(0, 7) == 0);
                v[58:56] = 3'($urandom);
                v[55] = ($urandom_range(0, 3) == 0);
                v[54:0] = {15'($urandom), 4'($urandom), 4'($urandom), 32'($urandom)};
                set_req(n[0], v);
            end
            mi.addr_ack = ($urandom_range(0, 5) == 0);
            mi.rd_rs = ($urandom_range(0, 3) == 0);
            mi.mb_read = {4'($urandom), 32'($urandom)};
            reset = ($urandom_range(0, 199) == 0);
            tick();
        end
        set_req(0, '0);
        set_req(1, '0);
        mi.addr_ack = 1'b0;
        mi.rd_rs = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mem_on = 1'b1;
        core[4] = 36'd123;
        ff[3] = 36'o777777666666;
        set_req(0, {1'b1, 1'b1, 3'b000, 15'd4, 4'h0, 36'd0});
        #1;
        chk("lat_idle", 64'(mi.rq_cyc), 64'd0);
        tick();
        #1;
        chk("lat_grant", 64'(mi.rq_cyc), 64'd1);
        xfer(0, 0, 0, 15'd4, 36'd0, d);
        chk("read4", 64'(d), 64'd123);
        xfer(0, 0, 1, 15'd3, 36'd0, d);
        chk("fmc_read", 64'(d), 64'(36'o777777666666));
        xfer(1, 1, 0, 15'o123, 36'o112233445566, d);
        xfer(0, 0, 0, 15'o123, 36'd0, d);
        chk("write_back", 64'(d), 64'(36'o112233445566));
        set_req(0, {1'b1, 1'b1, 3'b000, 15'd5, 4'hf, 36'd0});
        tick();
        #1;
        set_req(1, {1'b1, 1'b1, 3'b000, 15'd4, 4'h0, 36'd0});
        k = 0;
        while (!tmo && k < 20) begin
            tick();
            #1;
            k++;
        end
        chk("tmo_delay", 64'(k), 64'd8);
        set_req(0, '0);
        tick();
        #1;
        chk("tmo_width", 64'(tmo), 64'd0);
        chk("tmo_next_owner", 64'(owner), 64'd1);
        xfer(1, 0, 0, 15'd4, 36'd0, d);
        chk("tmo_next_read", 64'(d), 64'd123);
        mem_hold = 1'b1;
        set_req(0, {1'b1, 1'b1, 3'b000, 15'd4, 4'h0, 36'd0});
        tick();
        tick();
        #1;
        chk("data_wait", 64'(mi.rq_cyc), 64'd1);
        #1 reset = 1'b1;
        #1;
        chk("rst_async_m", 64'(mout()), 64'd0);
        chk("rst_async_s0", 64'({s0i.mb_read, s0i.addr_ack, s0i.rd_rs}), 64'd0);
        chk("rst_async_owner", 64'(owner), 64'd1);
        compare();
        tick();
        #1 reset = 1'b0;
        mem_hold = 1'b0;
        set_req(0, '0);
        tick();
        #1;
        set_req(1, {1'b1, 1'b1, 3'b000, 15'd4, 4'h0, 36'd0});
        xfer(0, 0, 0, 15'd4, 36'd0, d);
        chk("tie1_owner", 64'(owner), 64'd0);
        xfer(1, 0, 0, 15'd4, 36'd0, d);
        chk("tie1_s1_owner", 64'(owner), 64'd1);
        chk("tie1_s1_read", 64'(d), 64'd123);
        set_req(1, {1'b1, 1'b1, 3'b000, 15'd4, 4'h0, 36'd0});
        xfer(0, 0, 0, 15'd4, 36'd0, d);
        chk("tie2_owner", 64'(owner), 64'd0);
        set_req(1, '0);
        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
